// File: rtl/d_grf_fwd.sv
// rtl/d_grf_fwd.sv - D-stage GPR file with E/M/W operand bypass
module d_grf_fwd #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    D_A1,
    input  logic [4:0]    D_A2,
    input  logic [4:0]    E_fwd_A3,
    input  logic [DW-1:0] E_fwd_WD,
    input  logic          E_fwd_valid,
    input  logic [4:0]    M_fwd_A3,
    input  logic [DW-1:0] M_fwd_WD,
    input  logic          M_fwd_valid,
    input  logic [4:0]    W_A3,
    input  logic [DW-1:0] W_WD,
    input  logic          W_WE,
    output logic [DW-1:0] D_Rdata1,
    output logic [DW-1:0] D_Rdata2
);

    logic [DW-1:0] regs_q [NREG];

    // $0 is never written, so its entry stays at the reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (W_WE && (W_A3 != 5'd0)) begin
            regs_q[W_A3] <= W_WD;
        end
    end

    // Youngest producer wins: E over M over same-cycle W write-through over the array.
    always_comb begin
        D_Rdata1 = '0;
        if (!reset || (D_A1 == 5'd0)) begin
            D_Rdata1 = '0;
        end else if (E_fwd_valid && (E_fwd_A3 == D_A1)) begin
            D_Rdata1 = E_fwd_WD;
        end else if (M_fwd_valid && (M_fwd_A3 == D_A1)) begin
            D_Rdata1 = M_fwd_WD;
        end else if (W_WE && (W_A3 == D_A1)) begin
            D_Rdata1 = W_WD;
        end else begin
            D_Rdata1 = regs_q[D_A1];
        end
    end

    always_comb begin
        D_Rdata2 = '0;
        if (!reset || (D_A2 == 5'd0)) begin
            D_Rdata2 = '0;
        end else if (E_fwd_valid && (E_fwd_A3 == D_A2)) begin
            D_Rdata2 = E_fwd_WD;
        end else if (M_fwd_valid && (M_fwd_A3 == D_A2)) begin
            D_Rdata2 = M_fwd_WD;
        end else if (W_WE && (W_A3 == D_A2)) begin
            D_Rdata2 = W_WD;
        end else begin
            D_Rdata2 = regs_q[D_A2];
        end
    end

endmodule

// File: doc/d_grf_fwd.md
Name: d_grf_fwd

Overview:
- D-stage register file plus operand-forwarding network. Produces the two operands D_Rdata1/D_Rdata2 consumed by the D-stage comparator (branch decision) and latched into the D/E pipeline register.
- Holds the 32x32 GPR array, written by W stage.
- Resolves RAW hazards for D-stage reads by bypassing results already available in E, M and W stages.
- The stall decision for results not yet produced lives in the hazard unit, not here.

Parameters:
- NREG, 32, number of architectural registers (address width fixed at 5).
- DW, 32, data width.

Ports:
- clk  input  1  pipeline clock; array writes on rising edge
- reset  input  1  asynchronous, active-low reset
- D_A1  input  5  read address, port 1 (rs)
- D_A2  input  5  read address, port 2 (rt)
- E_fwd_A3  input  5  destination register of instruction in E
- E_fwd_WD  input  DW  result available in E (e.g. lui/jal link value)
- E_fwd_valid  input  1  E_fwd_WD is final for E_fwd_A3
- M_fwd_A3  input  5  destination register of instruction in M
- M_fwd_WD  input  DW  result available in M
- M_fwd_valid  input  1  M_fwd_WD is final
- W_A3  input  5  write-back address
- W_WD  input  DW  write-back data
- W_WE  input  1  write enable
- D_Rdata1  output  DW  forwarded operand 1
- D_Rdata2  output  DW  forwarded operand 2

Behaviour:
- Storage: array of NREG x DW flops.
  - reset low clears all entries to 0 asynchronously, independent of clk.
  - While reset is low, writes are ignored.
- Write: on posedge clk with reset high, W_WE=1 and W_A3!=0, array[W_A3] <= W_WD.
  - Writes to $0 are discarded; array[0] reads 0 always.
- Read: fully combinational, zero-cycle latency. Per port, with address A:
  1. A==0 -> 0. Never forwarded, even if some stage targets $0.
  2. else if E_fwd_valid && E_fwd_A3==A -> E_fwd_WD.
  3. else if M_fwd_valid && M_fwd_A3==A -> M_fwd_WD.
  4. else if W_WE && W_A3==A -> W_WD. This is write-through: the same-cycle W write is visible before the edge.
  5. else array[A].
- Priority is E > M > W > array, so the youngest producer wins.
  - Example: E and M both target $5 -> E value.
- A valid=0 stage never matches, regardless of its A3/WD values.
- Both ports resolve independently. D_A1==D_A2 yields identical outputs.
- Outputs during reset low: both forced to 0, forwarding inputs ignored.
- Reset released mid-cycle: the array stays all-zero until the first qualifying posedge write. Forwarding resumes immediately.
- No internal pipeline state besides the array. Next-cycle reads see the new array value.
- Width rule: DW-bit data pass unmodified, with no sign or zero extension.

Test Plan:
- Reset: assert reset=0 with W_WE=1, W_A3=3, W_WD=0xDEADBEEF across an edge, then release. Required: D_A1=3 reads 0x00000000 and all 32 registers read 0.
- Write/readback: W writes 0x12345678 to $8 on edge N. Required: D_A1=8 reads 0x12345678 in cycle N (write-through) and in cycle N+1 (array), with all bypass valids=0.
- $0 protection: W_WE=1, W_A3=0, W_WD=0xFFFFFFFF, with E_fwd_valid=1, E_fwd_A3=0, E_fwd_WD=0xAAAA. Required: D_A1=0 reads 0 in the same and the next cycle.
- Priority: array $5=1, W writes 2, M_fwd=(5,3,valid), E_fwd=(5,4,valid).
  - Required: D_Rdata1=4.
  - Drop E valid -> 3.
  - Drop M valid -> 2.
  - Drop W_WE -> 1.
- Independent ports: D_A1=5, D_A2=6, E targets $6 with 0x77, $5 holds 0x11. Required: D_Rdata1=0x11, D_Rdata2=0x77.
- Async reset mid-operation: assert reset between edges after $9=0xCAFE is written. Required: D_Rdata1 (A1=9) drops to 0 immediately without a clock edge, and still reads 0 after release until $9 is rewritten.
